// File: rtl/alu_share_pkg.sv
// alu_share_pkg: shared opcode constants and FSM state encoding for the
// shared-ALU arbiter and its combinational core.
// Optional feature macro used by the importing files: ALU_SHARE_FLAGS_EN.
package alu_share_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: request/response bundle between two issuers, the
// result consumer and the shared ALU arbiter.
//   req0_*/req1_* : valid/ready request channels (op, R2, R3)
//   rsp_*         : held response channel (valid/ready, id, R1, c_out)
//   zero/ovf      : extra result flags, present only with ALU_SHARE_FLAGS_EN
// Modports: master = requesters/consumer side, slave = arbiter side.
interface alu_share_arb_if #(
    parameter int unsigned size = 4
);
    logic            req0_valid;
    logic            req0_ready;
    logic [2:0]      req0_op;
    logic [size-1:0] req0_R2;
    logic [size-1:0] req0_R3;

    logic            req1_valid;
    logic            req1_ready;
    logic [2:0]      req1_op;
    logic [size-1:0] req1_R2;
    logic [size-1:0] req1_R3;

    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [size-1:0] R1;
    logic            c_out;
`ifdef ALU_SHARE_FLAGS_EN
    logic            zero;
    logic            ovf;
`endif

    modport master (
        output req0_valid, req0_op, req0_R2, req0_R3,
        input  req0_ready,
        output req1_valid, req1_op, req1_R2, req1_R3,
        input  req1_ready,
        output rsp_ready,
        input  rsp_valid, rsp_id, R1, c_out
`ifdef ALU_SHARE_FLAGS_EN
        , input zero, ovf
`endif
    );

    modport slave (
        input  req0_valid, req0_op, req0_R2, req0_R3,
        output req0_ready,
        input  req1_valid, req1_op, req1_R2, req1_R3,
        output req1_ready,
        input  rsp_ready,
        output rsp_valid, rsp_id, R1, c_out
`ifdef ALU_SHARE_FLAGS_EN
        , output zero, ovf
`endif
    );

endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU (add/sub/and/or/slt), reusable by the
// ALU blocks.
//   op    : opcode (101-111 give R1=0, c_out=0)
//   R2,R3 : operands
//   R1    : result, c_out : carry out (SUB/SLT: 1 = no borrow)
//   zero, ovf : present only with ALU_SHARE_FLAGS_EN
module alu_core
    import alu_share_pkg::*;
#(
    parameter int unsigned size = 4
) (
    input  logic [2:0]      op,
    input  logic [size-1:0] R2,
    input  logic [size-1:0] R3,
    output logic [size-1:0] R1,
    output logic            c_out
`ifdef ALU_SHARE_FLAGS_EN
    ,
    output logic            zero,
    output logic            ovf
`endif
);
    logic [size:0] add_w;
    logic [size:0] sub_w;
    logic          sub_ovf;
    logic          slt;

    assign add_w   = {1'b0, R2} + {1'b0, R3};
    assign sub_w   = {1'b0, R2} + {1'b0, ~R3} + {{size{1'b0}}, 1'b1};
    assign sub_ovf = (R2[size-1] != R3[size-1]) && (sub_w[size-1] != R2[size-1]);
    // Signed less-than: sign of the difference corrected by overflow.
    assign slt     = sub_w[size-1] ^ sub_ovf;

    always_comb begin
        R1    = '0;
        c_out = 1'b0;
        case (op)
            OP_ADD: begin
                R1    = add_w[size-1:0];
                c_out = add_w[size];
            end
            OP_SUB: begin
                R1    = sub_w[size-1:0];
                c_out = sub_w[size];
            end
            OP_AND: R1 = R2 & R3;
            OP_OR:  R1 = R2 | R3;
            OP_SLT: begin
                R1    = {{(size-1){1'b0}}, slt};
                c_out = sub_w[size];
            end
            default: begin
                R1    = '0;
                c_out = 1'b0;
            end
        endcase
    end

`ifdef ALU_SHARE_FLAGS_EN
    logic add_ovf;
    assign add_ovf = (R2[size-1] == R3[size-1]) && (add_w[size-1] != R2[size-1]);
    assign zero    = (R1 == '0);

    always_comb begin
        ovf = 1'b0;
        case (op)
            OP_ADD:          ovf = add_ovf;
            OP_SUB, OP_SLT:  ovf = sub_ovf;
            default:         ovf = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one registered alu_core between two requesters.
// Round-robin arbitration in IDLE, one cycle of execution in EXEC, and a held
// response in RESP until the consumer takes it (1 op / 3 cycles peak).
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : alu_share_arb_if.slave (request channels, response channel)
// Optional macro ALU_SHARE_FLAGS_EN adds registered zero/ovf outputs.
module alu_share_arb
    import alu_share_pkg::*;
#(
    parameter int unsigned size = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_share_arb_if.slave bus
);
    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic [2:0]      op_q, op_d;
    logic [size-1:0] a_q, a_d;
    logic [size-1:0] b_q, b_d;
    logic            id_q, id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [size-1:0] r1_q, r1_d;
    logic            c_out_q, c_out_d;
    logic            grant0, grant1;
    logic [size-1:0] alu_r1;
    logic            alu_c;
`ifdef ALU_SHARE_FLAGS_EN
    logic            zero_q, zero_d, ovf_q, ovf_d;
    logic            alu_zero, alu_ovf;
`endif

    alu_core #(.size(size)) u_alu (
        .op    (op_q),
        .R2    (a_q),
        .R3    (b_q),
        .R1    (alu_r1),
        .c_out (alu_c)
`ifdef ALU_SHARE_FLAGS_EN
        ,
        .zero  (alu_zero),
        .ovf   (alu_ovf)
`endif
    );

    // State and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            r1_q        <= '0;
            c_out_q     <= 1'b0;
`ifdef ALU_SHARE_FLAGS_EN
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            r1_q        <= r1_d;
            c_out_q     <= c_out_d;
`ifdef ALU_SHARE_FLAGS_EN
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        r1_d        = r1_q;
        c_out_d     = c_out_q;
`ifdef ALU_SHARE_FLAGS_EN
        zero_d      = zero_q;
        ovf_d       = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    op_d    = grant1 ? bus.req1_op : bus.req0_op;
                    a_d     = grant1 ? bus.req1_R2 : bus.req0_R2;
                    b_d     = grant1 ? bus.req1_R3 : bus.req0_R3;
                    id_d    = grant1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                r1_d        = alu_r1;
                c_out_d     = alu_c;
`ifdef ALU_SHARE_FLAGS_EN
                zero_d      = alu_zero;
                ovf_d       = alu_ovf;
`endif
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    last_d      = rsp_id_q;
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: grants only in IDLE; on a tie the requester that was not
    // served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == S_IDLE) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || last_q);
            grant1 = bus.req1_valid && (!bus.req0_valid || !last_q);
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.R1         = r1_q;
    assign bus.c_out      = c_out_q;
`ifdef ALU_SHARE_FLAGS_EN
    assign bus.zero       = zero_q;
    assign bus.ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: self-checking bench for alu_share_arb (size=4).
// Directed vector table, hand-written multi-cycle sequences (contention,
// backpressure, reset mid-operation) and randomized traffic against a
// behavioural model. Flag outputs are checked when ALU_SHARE_FLAGS_EN is set.
module tb_alu_share_arb;
    localparam int SIZE = 4;
    localparam int M    = 1 << SIZE;
    localparam int H    = M / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_share_arb_if #(.size(SIZE)) bus ();

    alu_share_arb #(.size(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int r;
        int c;
        int z;
        int o;
    } exp_t;

    typedef struct {
        bit             id;
        logic [2:0]     op;
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        int             r;
        int             c;
        int             z;
        int             o;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU from the opcode definitions using plain integer arithmetic.
    function automatic exp_t ref_alu(input logic [2:0] op, input int a, input int b);
        exp_t e;
        int sa, sb, sv;
        sa = (a >= H) ? a - M : a;
        sb = (b >= H) ? b - M : b;
        e = '{0, 0, 0, 0};
        case (op)
            3'd0: begin
                e.r = (a + b) % M; e.c = (a + b >= M);
                sv = sa + sb; e.o = (sv < -H || sv >= H);
            end
            3'd1: begin
                e.r = (a - b + M) % M; e.c = (a >= b);
                sv = sa - sb; e.o = (sv < -H || sv >= H);
            end
            3'd2: e.r = a & b;
            3'd3: e.r = a | b;
            3'd4: begin
                e.r = (sa < sb); e.c = (a >= b);
                sv = sa - sb; e.o = (sv < -H || sv >= H);
            end
            default: ;
        endcase
        e.z = (e.r == 0);
        return e;
    endfunction

    task automatic set_req(input int id, input bit v, input logic [2:0] op,
                           input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_R2 = a; bus.req0_R3 = b;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_R2 = a; bus.req1_R3 = b;
        end
    endtask

    task automatic check_rsp(input string tag, input exp_t e, input int id);
        check({tag, ".R1"},     32'(bus.R1),     32'(e.r));
        check({tag, ".c_out"},  32'(bus.c_out),  32'(e.c));
        check({tag, ".rsp_id"}, 32'(bus.rsp_id), 32'(id));
`ifdef ALU_SHARE_FLAGS_EN
        check({tag, ".zero"},   32'(bus.zero),   32'(e.z));
        check({tag, ".ovf"},    32'(bus.ovf),    32'(e.o));
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        set_req(0, 0, 3'd0, '0, '0);
        set_req(1, 0, 3'd0, '0, '0);
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] readies();
        return 32'({bus.req1_ready, bus.req0_ready});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vec[10];
        exp_t e;
        int   acc_id[$];
        int   acc_cyc[$];
        logic [SIZE-1:0] held;
        bit   m_busy, m_id, m_last, v0, v1, e0, e1, exp_v;
        int   m_acc;
        exp_t m_e;

        vec[0] = '{0, 3'b000, 4'd7,  4'd9,  0,  1, 1, 0};
        vec[1] = '{1, 3'b100, 4'd12, 4'd3,  1,  1, 0, 0};
        vec[2] = '{1, 3'b100, 4'd3,  4'd12, 0,  0, 1, 0};
        vec[3] = '{0, 3'b001, 4'd5,  4'd5,  0,  1, 1, 0};
        vec[4] = '{0, 3'b000, 4'd7,  4'd1,  8,  0, 0, 1};
        vec[5] = '{1, 3'b010, 4'd12, 4'd10, 8,  0, 0, 0};
        vec[6] = '{0, 3'b011, 4'd5,  4'd10, 15, 0, 0, 0};
        vec[7] = '{1, 3'b111, 4'd15, 4'd15, 0,  0, 1, 0};
        vec[8] = '{0, 3'b001, 4'd3,  4'd5,  14, 0, 0, 0};
        vec[9] = '{1, 3'b100, 4'd8,  4'd7,  1,  1, 0, 1};

        set_req(0, 0, 3'd0, '0, '0);
        set_req(1, 0, 3'd0, '0, '0);
        bus.rsp_ready = 1'b0;

        // Reset state
        apply_reset();
        #1;
        check("rst.rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst.R1",        32'(bus.R1),        0);
        check("rst.c_out",     32'(bus.c_out),     0);
        check("rst.rsp_id",    32'(bus.rsp_id),    0);
        check("rst.ready",     readies(),          0);

        // Directed table: single requester, accept at T, response at T+2
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_req(vec[i].id, 1, vec[i].op, vec[i].a, vec[i].b);
            #1;
            check("tbl.ready", readies(), vec[i].id ? 2 : 1);
            @(posedge clk);
            @(negedge clk);
            // Changes after acceptance must be ignored
            set_req(vec[i].id, 0, 3'($urandom), SIZE'($urandom), SIZE'($urandom));
            #1;
            check("tbl.exec_valid", 32'(bus.rsp_valid), 0);
            @(negedge clk);
            #1;
            check("tbl.rsp_valid", 32'(bus.rsp_valid), 1);
            check_rsp("tbl", '{vec[i].r, vec[i].c, vec[i].z, vec[i].o}, vec[i].id);
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            #1;
            check("tbl.rsp_done", 32'(bus.rsp_valid), 0);
        end

        // Contention: 0 wins first after reset, then alternation every 3 cycles
        apply_reset();
        set_req(0, 1, 3'd0, 4'd1, 4'd2);
        set_req(1, 1, 3'd3, 4'd4, 4'd8);
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            check("cont.onehot", 32'(bus.req0_ready & bus.req1_ready), 0);
            if (bus.req0_ready || bus.req1_ready) begin
                acc_id.push_back(bus.req1_ready ? 1 : 0);
                acc_cyc.push_back(c);
            end
            @(negedge clk);
        end
        check("cont.count", 32'(acc_id.size()), 4);
        if (acc_id.size() == 4) begin
            check("cont.first_cyc", 32'(acc_cyc[0]), 0);
            for (int k = 0; k < 4; k++) begin
                check("cont.id", 32'(acc_id[k]), 32'(k % 2));
                if (k > 0) check("cont.gap", 32'(acc_cyc[k] - acc_cyc[k-1]), 3);
            end
        end

        // Backpressure: held response, no grants while busy
        apply_reset();
        set_req(1, 1, 3'd0, 4'd3, 4'd4);
        #1;
        check("bp.ready", readies(), 2);
        @(posedge clk);
        @(negedge clk);
        set_req(1, 0, 3'd0, '0, '0);
        @(negedge clk);
        set_req(0, 1, 3'd2, 4'd15, 4'd1);
        set_req(1, 1, 3'd3, 4'd2, 4'd1);
        held = bus.R1;
        check("bp.R1", 32'(held), 7);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp.rsp_valid", 32'(bus.rsp_valid), 1);
            check("bp.R1_stable", 32'(bus.R1), 32'(held));
            check("bp.ready_low", readies(), 0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("bp.release_valid", 32'(bus.rsp_valid), 0);
        check("bp.release_rr", readies(), 1);
        set_req(0, 0, 3'd0, '0, '0);
        set_req(1, 0, 3'd0, '0, '0);
        bus.rsp_ready = 1'b0;

        // Reset during EXEC with both requesters valid
        apply_reset();
        set_req(0, 1, 3'd0, 4'd3, 4'd4);
        set_req(1, 1, 3'd0, 4'd5, 4'd6);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rexec.rsp_valid", 32'(bus.rsp_valid), 0);
        check("rexec.R1", 32'(bus.R1), 0);
        check("rexec.ready", readies(), 1);
        set_req(0, 0, 3'd0, '0, '0);
        set_req(1, 0, 3'd0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("rexec.no_rsp", 32'(bus.rsp_valid), 0);
        end

        // Reset during RESP: held response is discarded
        apply_reset();
        set_req(0, 1, 3'd0, 4'd3, 4'd4);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 0, 3'd0, '0, '0);
        @(negedge clk);
        #1;
        check("rresp.R1_before", 32'(bus.R1), 7);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rresp.rsp_valid", 32'(bus.rsp_valid), 0);
        check("rresp.R1", 32'(bus.R1), 0);
        check("rresp.c_out", 32'(bus.c_out), 0);

        // Randomized traffic against the behavioural model
        apply_reset();
        m_busy = 0; m_id = 0; m_last = 1; m_acc = 0; m_e = '{0, 0, 0, 0};
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            v0 = ($urandom_range(0, 9) < 6);
            v1 = ($urandom_range(0, 9) < 6);
            set_req(0, v0, 3'($urandom_range(0, 7)), SIZE'($urandom), SIZE'($urandom));
            set_req(1, v1, 3'($urandom_range(0, 7)), SIZE'($urandom), SIZE'($urandom));
            bus.rsp_ready = 1'($urandom_range(0, 1));
            #1;
            e0 = !m_busy && v0 && (!v1 || m_last);
            e1 = !m_busy && v1 && (!v0 || !m_last);
            check("rnd.ready", readies(), 32'({e1, e0}));
            exp_v = m_busy && (cyc >= m_acc + 2);
            check("rnd.rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
            if (exp_v) check_rsp("rnd", m_e, m_id);
            if (e0 || e1) begin
                m_busy = 1;
                m_acc  = cyc;
                m_id   = e1;
                if (e1) m_e = ref_alu(bus.req1_op, int'(bus.req1_R2), int'(bus.req1_R3));
                else    m_e = ref_alu(bus.req0_op, int'(bus.req0_R2), int'(bus.req0_R3));
            end else if (exp_v && bus.rsp_ready) begin
                m_busy = 0;
                m_last = m_id;
            end
        end

        // Model sanity against hand-computed table entries
        for (int i = 0; i < 10; i++) begin
            e = ref_alu(vec[i].op, int'(vec[i].a), int'(vec[i].b));
            check("model.r", 32'(e.r), 32'(vec[i].r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
Shares one registered ALU datapath (add/sub/and/or/slt, same R1/R2/R3/c_out convention as the existing ALU modules) between two requesters. Round-robin arbitration, valid/ready request handshake, and a single held response channel tagged with the requester id. Sits between two instruction issuers and the shared `alu_core`.

Parameters:
- size, 4, operand/result width in bits (≥2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- req0_valid  input  1  requester 0 has an op
- req0_ready  output  1  requester 0 op accepted this cycle
- req0_op  input  3  requester 0 opcode
- req0_R2  input  size  requester 0 operand A
- req0_R3  input  size  requester 0 operand B
- req1_valid / req1_ready / req1_op / req1_R2 / req1_R3  same as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_id  output  1  requester that owns the result
- R1  output  size  result
- c_out  output  1  carry/no-borrow

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE; rsp_valid=0; rsp_id=0; R1=0; c_out=0; rr pointer last=1, so requester 0 wins the first tie.
- FSM IDLE:
  - If any reqN_valid, select winner: the sole requester, or on a tie the one ≠ last.
  - reqN_ready=1 combinationally for the winner only; the transfer occurs that cycle.
  - Latch op, R2, R3 and id; go to EXEC.
  - No valid: stay.
- FSM EXEC: `alu_core` computes on the latched operands. Register R1, c_out and rsp_id. Go to RESP.
- FSM RESP:
  - rsp_valid=1. R1, c_out and rsp_id are held stable.
  - On rsp_ready=1: last←rsp_id, rsp_valid←0, go to IDLE.
- Ready rule: reqN_ready is 0 in EXEC and RESP.
- Latency and throughput:
  - Accept at cycle T; rsp_valid is high from T+2.
  - Peak throughput is 1 op / 3 cycles.
- Opcodes (arithmetic mod 2^size):
  - 000 ADD: R1=R2+R3; c_out=carry out of MSB.
  - 001 SUB: R1=R2+~R3+1; c_out=carry out (1 = no borrow).
  - 010 AND: R1=R2&R3; c_out=0.
  - 011 OR: R1=R2|R3; c_out=0.
  - 100 SLT: signed compare; R1={0…,(R2<R3)}; c_out=carry of R2−R3.
  - 101–111: R1=0, c_out=0. Still a legal, accepted transaction.
- Boundaries:
  - A requester dropping valid without ready is legal; no state change.
  - Operand/op changes while not accepted are ignored.
  - rsp_ready high outside RESP is ignored.
- Reset mid-operation: in-flight op discarded, no response issued, all reset values restored next cycle.

Optional Feature:
- ALU_SHARE_FLAGS_EN, when defined, adds two outputs, both registered in EXEC alongside R1 and 0 on reset:
  - zero (1): R1==0.
  - ovf (1): signed overflow, for ADD/SUB/SLT only; 0 for other ops.
- When undefined: ports absent, behaviour otherwise identical.

Decomposition:
- Package `alu_share_pkg`:
  - Opcode localparams OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT.
  - State encoding S_IDLE, S_EXEC, S_RESP.
- Sub-module `alu_core` (parameter size, purely combinational: op, R2, R3 → R1, c_out [, zero, ovf]), reusable by other ALU blocks.
- The arbiter, FSM and response registers stay in `alu_share_arb`.

Test Plan (size=4):
- Single ADD: req0 ADD R2=7, R3=9 → req0_ready at T; rsp_valid at T+2 with R1=0000, c_out=1, rsp_id=0.
- SLT signed: req1 SLT R2=1100(−4), R3=0011 → R1=0001, rsp_id=1. Then R2=0011, R3=1100 → R1=0000.
- Contention: both valid continuously, rsp_ready=1 → accept order 0,1,0,1; each accept 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid stays 1, R1 stable, both reqN_ready=0. Release → IDLE next cycle.
- Reset mid-op: rst asserted during EXEC with both valid → next cycle rsp_valid=0, R1=0. After reset, requester 0 wins first.
- With ALU_SHARE_FLAGS_EN defined:
  - SUB 5−5 → R1=0000, c_out=1, zero=1.
  - ADD 7+1 → R1=1000, ovf=1, zero=0.
